// File: rtl/key_counter_mc.sv
// -----------------------------------------------------------------------------
// key_counter_mc
//
// Multi-channel push-button counter. Each channel takes one raw, active-low
// key, brings it into the clk domain with a two-flop synchroniser, debounces
// it and turns the released->pressed transition of the debounced state into
// a single press event. Every event steps that channel's counter up or down,
// either wrapping or saturating at the ends of the range. One counter is
// selected onto a registered LED bus, and the per-channel press events are
// exported as one-cycle pulses.
//
// Optional build macro:
//   KEY_COUNTER_MC_AUTOREPEAT_EN
//     When defined, a key held down after its initial press generates an
//     additional event every REPEAT_CYCLES cycles. When undefined, a held
//     key produces exactly one event and REPEAT_CYCLES has no effect.
//
// Parameters:
//   WIDTH            counter and LED bus width (>= 2)
//   CHANNELS         number of independent key/counter channels (>= 1)
//   SEL_W            width of sel, 2**SEL_W >= CHANNELS
//   DEBOUNCE_CYCLES  consecutive cycles a key must disagree with its stable
//                    state before that state flips (>= 2)
//   REPEAT_CYCLES    auto-repeat period, auto-repeat builds only (>= 2)
//
// Ports:
//   clk          system clock
//   rstn         asynchronous active-low reset
//   keys         raw push-buttons, active-low, asynchronous to clk
//   dir          1 = count up, 0 = count down (all channels)
//   sat          1 = saturate at 0 / max, 0 = wrap around
//   clr          synchronous clear of every counter, wins over a same-cycle
//                event
//   sel          channel shown on leds; out-of-range selects show 0
//   leds         registered copy of the selected counter
//   press_pulse  one-cycle pulse per counted event, per channel
// -----------------------------------------------------------------------------
module key_counter_mc #(
  parameter int WIDTH           = 8,
  parameter int CHANNELS        = 2,
  parameter int SEL_W           = 1,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_CYCLES   = 64
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [CHANNELS-1:0] keys,
  input  logic                dir,
  input  logic                sat,
  input  logic                clr,
  input  logic [SEL_W-1:0]    sel,
  output logic [WIDTH-1:0]    leds,
  output logic [CHANNELS-1:0] press_pulse
);

  // ---------------------------------------------------------------------------
  // Derived constants
  // ---------------------------------------------------------------------------
  localparam int              DBC_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DBC_W-1:0] DBC_LAST = DBC_W'(DEBOUNCE_CYCLES - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  // Synchroniser chain: s1 may go metastable, s2 is the clean sampled key.
  logic [CHANNELS-1:0] s1_q, s1_d;
  logic [CHANNELS-1:0] s2_q, s2_d;

  // Debounced key level (1 = released) and the disagreement run length.
  logic [CHANNELS-1:0] stable_q, stable_d;
  logic [DBC_W-1:0]    dbc_q [CHANNELS];
  logic [DBC_W-1:0]    dbc_d [CHANNELS];

  // Per-channel counters, the LED register and the exported pulses.
  logic [WIDTH-1:0]    cnt_q [CHANNELS];
  logic [WIDTH-1:0]    cnt_d [CHANNELS];
  logic [WIDTH-1:0]    leds_q, leds_d;
  logic [CHANNELS-1:0] press_pulse_q, press_pulse_d;

  // press_ev: the debounced 1->0 transition happening at this edge.
  // count_ev: every event that steps a counter (press plus any repeat).
  logic [CHANNELS-1:0] press_ev;
  logic [CHANNELS-1:0] count_ev;

  // ---------------------------------------------------------------------------
  // One counter step under the current direction and end-of-range policy.
  // ---------------------------------------------------------------------------
  function automatic logic [WIDTH-1:0] step_count(
    input logic [WIDTH-1:0] cur,
    input logic             up,
    input logic             hold_at_end
  );
    logic [WIDTH-1:0] nxt;
    if (up) begin
      if (hold_at_end && (cur == {WIDTH{1'b1}})) nxt = cur;
      else                                       nxt = cur + WIDTH'(1);
    end else begin
      if (hold_at_end && (cur == '0)) nxt = cur;
      else                            nxt = cur - WIDTH'(1);
    end
    return nxt;
  endfunction

  // ---------------------------------------------------------------------------
  // Synchroniser and debounce
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned here gets a default first, so no path through
  // the block leaves a value unassigned and no latch can be inferred.
  always_comb begin
    s1_d     = keys;
    s2_d     = s1_q;
    stable_d = stable_q;
    press_ev = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      dbc_d[i] = dbc_q[i];
      if (s2_q[i] == stable_q[i]) begin
        // Key agrees with the debounced level: any partial run is abandoned,
        // which is what rejects glitches shorter than DEBOUNCE_CYCLES.
        dbc_d[i] = '0;
      end else if (dbc_q[i] == DBC_LAST) begin
        // Disagreement has lasted long enough: accept the new level. Only
        // the released->pressed direction is a press; release counts nothing.
        stable_d[i] = s2_q[i];
        dbc_d[i]    = '0;
        press_ev[i] = stable_q[i];
      end else begin
        dbc_d[i] = dbc_q[i] + DBC_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Auto-repeat
  // ---------------------------------------------------------------------------
`ifdef KEY_COUNTER_MC_AUTOREPEAT_EN
  localparam int              RPC_W    = $clog2(REPEAT_CYCLES);
  localparam logic [RPC_W-1:0] RPC_LAST = RPC_W'(REPEAT_CYCLES - 1);

  logic [RPC_W-1:0]    rpc_q [CHANNELS];
  logic [RPC_W-1:0]    rpc_d [CHANNELS];
  logic [CHANNELS-1:0] repeat_ev;

  // The repeat timer runs only while the debounced key is held. It restarts
  // on the initial press, so the first repeat lands REPEAT_CYCLES cycles after
  // it, and every later repeat another REPEAT_CYCLES cycles on.
  always_comb begin
    repeat_ev = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      rpc_d[i] = rpc_q[i];
      if (stable_q[i] || press_ev[i]) begin
        rpc_d[i] = '0;
      end else if (rpc_q[i] == RPC_LAST) begin
        repeat_ev[i] = 1'b1;
        rpc_d[i]     = '0;
      end else begin
        rpc_d[i] = rpc_q[i] + RPC_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < CHANNELS; i++) rpc_q[i] <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) rpc_q[i] <= rpc_d[i];
    end
  end

  assign count_ev = press_ev | repeat_ev;
`else
  // Without auto-repeat the period parameter plays no part; fold it into a
  // deliberately unused net so the parameter list stays identical across
  // both builds.
  logic unused_repeat_cycles;
  assign unused_repeat_cycles = ^REPEAT_CYCLES;

  assign count_ev = press_ev;
`endif

  // ---------------------------------------------------------------------------
  // Counters, pulses and LED select
  // ---------------------------------------------------------------------------
  always_comb begin
    press_pulse_d = count_ev;
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_d[i] = cnt_q[i];
      // clr wins over an event on the same edge; the pulse above still fires.
      if (clr)              cnt_d[i] = '0;
      else if (count_ev[i]) cnt_d[i] = step_count(cnt_q[i], dir, sat);
    end

    // Selects beyond the last channel fall through to the zero default.
    leds_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (sel == SEL_W'(i)) leds_d = cnt_q[i];
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: state is updated only with non-blocking assignments so that every
  // flop samples the values from before this edge, independent of the order
  // of the statements below.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_q          <= '1;
      s2_q          <= '1;
      stable_q      <= '1;
      leds_q        <= '0;
      press_pulse_q <= '0;
      // NOTE: these per-channel arrays are ordinary registers rather than a
      // RAM, so each entry is reset explicitly; a reset mid-debounce or
      // mid-count must leave no stale progress behind.
      for (int i = 0; i < CHANNELS; i++) begin
        dbc_q[i] <= '0;
        cnt_q[i] <= '0;
      end
    end else begin
      s1_q          <= s1_d;
      s2_q          <= s2_d;
      stable_q      <= stable_d;
      leds_q        <= leds_d;
      press_pulse_q <= press_pulse_d;
      for (int i = 0; i < CHANNELS; i++) begin
        dbc_q[i] <= dbc_d[i];
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign leds        = leds_q;
  assign press_pulse = press_pulse_q;

endmodule

// File: tb/tb_key_counter_mc.sv
// -----------------------------------------------------------------------------
// tb_key_counter_mc
//
// Self-checking bench for key_counter_mc with WIDTH=4, CHANNELS=2, SEL_W=1,
// DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8. Inputs are driven on the falling edge,
// outputs sampled 1 time unit after the rising edge. Expected counter values
// come from a table of hand-computed results and from an arithmetic model of
// the counting rules; expected pulse totals come from the number of presses
// issued. Builds with or without KEY_COUNTER_MC_AUTOREPEAT_EN.
// -----------------------------------------------------------------------------
module tb_key_counter_mc;

  localparam int WIDTH    = 4;
  localparam int CHANNELS = 2;
  localparam int SEL_W    = 1;
  localparam int DEB      = 4;
  localparam int REP      = 8;
  localparam int MAXV     = 2**WIDTH - 1;

  logic                clk = 1'b0;
  logic                rstn = 1'b1;
  logic [CHANNELS-1:0] keys = '1;
  logic                dir = 1'b1;
  logic                sat = 1'b0;
  logic                clr = 1'b0;
  logic [SEL_W-1:0]    sel = '0;
  logic [WIDTH-1:0]    leds;
  logic [CHANNELS-1:0] press_pulse;

  key_counter_mc #(
    .WIDTH          (WIDTH),
    .CHANNELS       (CHANNELS),
    .SEL_W          (SEL_W),
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_CYCLES  (REP)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .keys       (keys),
    .dir        (dir),
    .sat        (sat),
    .clr        (clr),
    .sel        (sel),
    .leds       (leds),
    .press_pulse(press_pulse)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------------
  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Pulse monitor: counts pulses per channel and logs the cycle of each
  // channel-0 pulse for spacing checks.
  int pulse_cnt [CHANNELS];
  int cyc = 0;
  int pulse_cyc [$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    for (int i = 0; i < CHANNELS; i++)
      if (press_pulse[i] === 1'b1) pulse_cnt[i] <= pulse_cnt[i] + 1;
    if (press_pulse[0] === 1'b1) pulse_cyc.push_back(cyc);
  end

  // ---------------------------------------------------------------------------
  // Reference model: counter values and expected pulse totals
  // ---------------------------------------------------------------------------
  int mdl [CHANNELS];
  int exp_pulses [CHANNELS];

  function automatic int step_ref(input int c, input bit up, input bit s);
    if (up) return s ? ((c >= MAXV) ? MAXV : c + 1) : (c + 1) % (MAXV + 1);
    else    return s ? ((c <= 0) ? 0 : c - 1)       : (c + MAXV) % (MAXV + 1);
  endfunction

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic apply_reset();
    @(negedge clk);
    rstn = 1'b0;
    keys = '1;
    clr  = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < CHANNELS; i++) mdl[i] = 0;
  endtask

  // Hold the masked keys low for 'hold' cycles (>= DEB), optionally raising
  // clr for exactly the event edge, then idle until released and settled.
  // The event edge is edge 5 counted from the first rising edge after drive.
  task automatic do_press(input logic [CHANNELS-1:0] mask, input logic d,
                          input logic s, input bit clr_ev, input int hold);
    @(negedge clk);
    dir  = d;
    sat  = s;
    keys = ~mask;
    for (int e = 0; e < hold + 10; e++) begin
      @(posedge clk);
      #1;
      if (e == 1 + DEB) check("pulse_at_event", 32'(press_pulse), 32'(mask));
      @(negedge clk);
      clr = (clr_ev && (e == DEB));
      if (e == hold - 1) keys = '1;
    end
    for (int i = 0; i < CHANNELS; i++) begin
      if (clr_ev)       mdl[i] = 0;
      else if (mask[i]) mdl[i] = step_ref(mdl[i], d, s);
      if (mask[i]) exp_pulses[i]++;
    end
  endtask

  task automatic glitch(input logic [CHANNELS-1:0] mask, input int len);
    @(negedge clk);
    keys = ~mask;
    repeat (len) @(negedge clk);
    keys = '1;
    repeat (2) @(negedge clk);
  endtask

  task automatic check_leds(input int ch, input int exp, input string name);
    @(negedge clk);
    sel = SEL_W'(ch);
    @(posedge clk);
    #1;
    check(name, 32'(leds), 32'(exp));
  endtask

  task automatic check_pulses(input string name);
    for (int i = 0; i < CHANNELS; i++) check(name, 32'(pulse_cnt[i]), 32'(exp_pulses[i]));
  endtask

  // ---------------------------------------------------------------------------
  // Table of presses with the counter values expected after each
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [CHANNELS-1:0] mask;
    logic                d;
    logic                s;
    int                  e0;
    int                  e1;
  } vec_t;

  vec_t tbl [10];

  initial begin
    #100_000_000;
    $display("FAIL watchdog: time limit reached before the summary");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{2'b01, 1'b1, 1'b0,  1, 0};
    tbl[1] = '{2'b10, 1'b1, 1'b0,  1, 1};
    tbl[2] = '{2'b11, 1'b1, 1'b0,  2, 2};
    tbl[3] = '{2'b01, 1'b0, 1'b0,  1, 2};
    tbl[4] = '{2'b10, 1'b0, 1'b1,  1, 1};
    tbl[5] = '{2'b01, 1'b0, 1'b0,  0, 1};
    tbl[6] = '{2'b01, 1'b0, 1'b1,  0, 1};
    tbl[7] = '{2'b01, 1'b0, 1'b0, 15, 1};
    tbl[8] = '{2'b01, 1'b1, 1'b1, 15, 1};
    tbl[9] = '{2'b11, 1'b1, 1'b0,  0, 2};

    // ---- reset state ------------------------------------------------------
    #2 rstn = 1'b0;
    #10;
    check("reset_leds", 32'(leds), 0);
    check("reset_pulse", 32'(press_pulse), 0);
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < CHANNELS; i++) mdl[i] = 0;

    // ---- clean press: exact pulse and LED timing --------------------------
    @(negedge clk);
    dir  = 1'b1;
    sat  = 1'b0;
    sel  = '0;
    keys = 2'b10;
    for (int e = 0; e < 16; e++) begin
      @(posedge clk);
      #1;
      if (e <= 7) begin
        check("clean_pulse_timing", 32'(press_pulse), (e == 1 + DEB) ? 32'd1 : 32'd0);
        check("clean_leds_timing", 32'(leds), (e >= 2 + DEB) ? 32'd1 : 32'd0);
      end
      @(negedge clk);
      if (e == 5) keys = '1;
    end
    mdl[0] = 1;
    exp_pulses[0]++;
    check_leds(1, 0, "clean_other_channel");
    check_pulses("clean_pulse_total");

    // ---- bounce rejection -------------------------------------------------
    apply_reset();
    for (int k = 0; k < 3; k++) glitch(2'b01, DEB - 1);
    repeat (6) @(negedge clk);
    check_pulses("bounce_no_pulse");
    check_leds(0, 0, "bounce_leds_zero");
    do_press(2'b01, 1'b1, 1'b0, 1'b0, 6);
    check_leds(0, 1, "bounce_then_hold");
    check_pulses("bounce_then_hold_pulses");

    // ---- table-driven sequence --------------------------------------------
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      do_press(tbl[i].mask, tbl[i].d, tbl[i].s, 1'b0, 5);
      check_leds(0, tbl[i].e0, "table_ch0");
      check_leds(1, tbl[i].e1, "table_ch1");
    end
    check_pulses("table_pulses");

    // ---- wrap and saturation ----------------------------------------------
    apply_reset();
    for (int k = 1; k <= 16; k++) begin
      do_press(2'b01, 1'b1, 1'b0, 1'b0, 4);
      if (k == 15) check_leds(0, 15, "wrap_reach_max");
    end
    check_leds(0, 0, "wrap_to_zero");
    begin
      int p0;
      p0 = pulse_cnt[0];
      for (int k = 0; k < 20; k++) do_press(2'b01, 1'b1, 1'b1, 1'b0, 4);
      check_leds(0, 15, "sat_hold_max");
      check("sat_pulses_fire", 32'(pulse_cnt[0] - p0), 20);
    end
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    mdl[0] = 0;
    mdl[1] = 0;
    check_leds(0, 0, "clr_idle");
    do_press(2'b01, 1'b0, 1'b0, 1'b0, 4);
    check_leds(0, 15, "down_wrap_from_zero");

    // ---- multi-channel and select latency ---------------------------------
    apply_reset();
    do_press(2'b11, 1'b1, 1'b0, 1'b0, 5);
    for (int k = 0; k < 3; k++) do_press(2'b10, 1'b1, 1'b0, 1'b0, 5);
    check_leds(0, 1, "multi_ch0");
    @(negedge clk);
    sel = 1'b1;
    #1;
    check("sel_change_old_value", 32'(leds), 1);
    @(posedge clk);
    #1;
    check("sel_change_new_value", 32'(leds), 4);
    check_leds(0, 1, "sel_back_ch0");
    check_pulses("multi_pulses");

    // ---- clr on the event edge --------------------------------------------
    do_press(2'b01, 1'b1, 1'b0, 1'b1, 6);
    check_leds(0, 0, "clr_event_ch0");
    check_leds(1, 0, "clr_event_ch1");
    check_pulses("clr_event_pulse");

    // ---- reset mid-debounce -----------------------------------------------
    do_press(2'b10, 1'b1, 1'b0, 1'b0, 5);
    @(negedge clk);
    keys = 2'b10;
    repeat (4) @(negedge clk);   // after edge 3: debounce run at 2
    rstn = 1'b0;
    keys = '1;
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < CHANNELS; i++) mdl[i] = 0;
    repeat (12) @(negedge clk);
    check_pulses("rst_mid_no_event");
    check_leds(0, 0, "rst_mid_leds0");
    check_leds(1, 0, "rst_mid_leds1");
    do_press(2'b01, 1'b1, 1'b0, 1'b0, 5);
    check_leds(0, 1, "rst_mid_then_press");

    // ---- long hold: auto-repeat or single event ---------------------------
    apply_reset();
    begin
      int n_exp;
`ifdef KEY_COUNTER_MC_AUTOREPEAT_EN
      n_exp = 4;
`else
      n_exp = 1;
`endif
      @(negedge clk);
      dir  = 1'b1;
      sat  = 1'b0;
      pulse_cyc.delete();
      keys = 2'b10;
      // Debounced level stays low for 30 cycles after the initial event.
      for (int e = 0; e < 50; e++) begin
        @(posedge clk);
        @(negedge clk);
        if (e == 29) keys = '1;
      end
      check("hold_event_count", 32'(pulse_cyc.size()), 32'(n_exp));
      for (int k = 1; k < pulse_cyc.size(); k++)
        check("repeat_spacing", 32'(pulse_cyc[k] - pulse_cyc[k-1]), REP);
      mdl[0] = n_exp;
      exp_pulses[0] += n_exp;
      check_leds(0, n_exp, "hold_leds");
    end

    // ---- randomized presses against the model ----------------------------
    apply_reset();
    for (int it = 0; it < 40; it++) begin
      logic [CHANNELS-1:0] m;
      logic                d;
      logic                s;
      bit                  c;
      int                  ch;
      m  = CHANNELS'($urandom_range(1, 3));
      d  = 1'($urandom_range(0, 1));
      s  = 1'($urandom_range(0, 1));
      c  = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 2) == 0) glitch(m, $urandom_range(1, DEB - 1));
      do_press(m, d, s, c, $urandom_range(DEB, 7));
      ch = $urandom_range(0, CHANNELS - 1);
      check_leds(ch, mdl[ch], "rand_leds");
      if (it % 8 == 7) check_pulses("rand_pulses");
    end
    check_leds(0, mdl[0], "rand_final_ch0");
    check_leds(1, mdl[1], "rand_final_ch1");
    check_pulses("final_pulses");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
